// File: rtl/spart_if.sv
// I/O-bus control signals and FIFO status flags shared between the processor side and the SPART.
// The bidirectional data bus stays a plain inout port on the SPART itself.
interface spart_if;
    logic       iocs_n;
    logic       iorw_n;
    logic [2:0] ioaddr;
    logic       tx_q_full;
    logic       rx_q_empty;

    modport master (output iocs_n, iorw_n, ioaddr, input tx_q_full, rx_q_empty);
    modport slave  (input iocs_n, iorw_n, ioaddr, output tx_q_full, rx_q_empty);
endinterface

// File: rtl/spart_param.sv
// Parametrised memory-mapped UART: TX/RX FIFOs, programmable divisor, stop bits, loopback, sticky errors.
// Define SPART_PARITY_EN to build the optional parity bit (control[3:2] live, parity_err reported).
module spart_param #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_RESET  = 433
) (
    input  logic       clk,
    input  logic       rst,
    spart_if.slave     bus,
    inout  wire  [7:0] databus,
    output logic       TX,
    input  logic       RX
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
`ifdef SPART_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic rd, wr, err_rd, flush, tx_push_req;
    logic [7:0] rdata;
    assign rd          = !bus.iocs_n && bus.iorw_n;
    assign wr          = !bus.iocs_n && !bus.iorw_n;
    assign err_rd      = rd && (bus.ioaddr == 3'd5);
    assign flush       = wr && (bus.ioaddr == 3'd4) && databus[7];
    assign tx_push_req = wr && (bus.ioaddr == 3'd0);
    assign databus     = rd ? rdata : 8'hzz;

    logic [12:0] db_reg;
    logic        loopback_reg, two_stop_reg, par_en_reg, par_odd_reg;
    logic        rx_ovf_reg, tx_ovf_reg, frame_err_reg, parity_err_reg;
    logic [12:0] div_eff;
    logic [13:0] div_plus;
    logic [12:0] half_m1;
    assign div_eff  = (db_reg < 13'd3) ? 13'd3 : db_reg;
    assign div_plus = {1'b0, div_eff} + 14'd1;
    assign half_m1  = 13'((div_plus >> 1) - 14'd1);

    // ---------------- FIFOs ----------------
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wptr_reg, tx_rptr_reg, rx_wptr_reg, rx_rptr_reg;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_pop, rx_push_ok;
    logic rx_push_reg;
    logic [DATA_W-1:0] rx_data_reg, tx_head;
    state_t tx_state_reg, rx_state_reg;

    assign tx_full    = (tx_wptr_reg[AW] != tx_rptr_reg[AW]) && (tx_wptr_reg[AW-1:0] == tx_rptr_reg[AW-1:0]);
    assign tx_empty   = (tx_wptr_reg == tx_rptr_reg);
    assign rx_full    = (rx_wptr_reg[AW] != rx_rptr_reg[AW]) && (rx_wptr_reg[AW-1:0] == rx_rptr_reg[AW-1:0]);
    assign rx_empty   = (rx_wptr_reg == rx_rptr_reg);
    assign tx_push    = tx_push_req && !tx_full;
    assign tx_pop     = (tx_state_reg == S_IDLE) && !tx_empty;
    assign rx_pop     = rd && (bus.ioaddr == 3'd0) && !rx_empty;
    // A flush empties the RX FIFO, so a byte landing on the same edge always fits.
    assign rx_push_ok = rx_push_reg && (flush || !rx_full);
    assign tx_head    = tx_mem[tx_rptr_reg[AW-1:0]];

    assign bus.tx_q_full  = tx_full;
    assign bus.rx_q_empty = rx_empty;

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wptr_reg[AW-1:0]] <= databus[DATA_W-1:0];
        if (rx_push_ok)
            rx_mem[flush ? '0 : rx_wptr_reg[AW-1:0]] <= rx_data_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wptr_reg <= '0;
            tx_rptr_reg <= '0;
            rx_wptr_reg <= '0;
            rx_rptr_reg <= '0;
        end else if (flush) begin
            tx_wptr_reg <= '0;
            tx_rptr_reg <= '0;
            rx_wptr_reg <= PW'(rx_push_ok);
            rx_rptr_reg <= '0;
        end else begin
            tx_wptr_reg <= tx_wptr_reg + PW'(tx_push);
            tx_rptr_reg <= tx_rptr_reg + PW'(tx_pop);
            rx_wptr_reg <= rx_wptr_reg + PW'(rx_push_ok);
            rx_rptr_reg <= rx_rptr_reg + PW'(rx_pop);
        end
    end

    logic [PW-1:0] tx_used, rx_used;
    logic [7:0]    tx_free, rx_cnt;
    logic [3:0]    tx_free_sat, rx_used_sat;
    assign tx_used     = tx_wptr_reg - tx_rptr_reg;
    assign rx_used     = rx_wptr_reg - rx_rptr_reg;
    assign tx_free     = 8'(FIFO_DEPTH) - 8'(tx_used);
    assign rx_cnt      = 8'(rx_used);
    assign tx_free_sat = (tx_free > 8'd15) ? 4'hF : tx_free[3:0];
    assign rx_used_sat = (rx_cnt > 8'd15) ? 4'hF : rx_cnt[3:0];

    // ---------------- TX engine ----------------
    logic [12:0] tx_cnt_reg, tx_div_reg;
    logic [2:0]  tx_idx_reg;
    logic [DATA_W-1:0] tx_shift_reg;
    logic tx_par_reg, tx_stop2_reg, tx_reg;
    assign TX = tx_reg;

    // The divisor is latched per frame so a mid-frame DB write cannot stretch the current frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_reg <= S_IDLE;
            tx_reg       <= 1'b1;
            tx_cnt_reg   <= '0;
            tx_div_reg   <= '0;
            tx_idx_reg   <= '0;
            tx_shift_reg <= '0;
            tx_par_reg   <= 1'b0;
            tx_stop2_reg <= 1'b0;
        end else begin
            case (tx_state_reg)
                S_IDLE: begin
                    tx_reg <= 1'b1;
                    if (!tx_empty) begin
                        tx_shift_reg <= tx_head;
                        tx_par_reg   <= (^tx_head) ^ par_odd_reg;
                        tx_div_reg   <= div_eff;
                        tx_cnt_reg   <= div_eff;
                        tx_idx_reg   <= '0;
                        tx_reg       <= 1'b0;
                        tx_state_reg <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt_reg == '0) begin
                        tx_reg       <= tx_shift_reg[0];
                        tx_cnt_reg   <= tx_div_reg;
                        tx_state_reg <= S_DATA;
                    end else
                        tx_cnt_reg <= tx_cnt_reg - 13'd1;
                end
                S_DATA: begin
                    if (tx_cnt_reg == '0) begin
                        tx_cnt_reg <= tx_div_reg;
                        if (tx_idx_reg == 3'(DATA_W - 1)) begin
                            tx_stop2_reg <= two_stop_reg;
                            tx_reg       <= par_en_reg ? tx_par_reg : 1'b1;
                            tx_state_reg <= par_en_reg ? S_PARITY : S_STOP;
                        end else begin
                            tx_shift_reg <= tx_shift_reg >> 1;
                            tx_reg       <= tx_shift_reg[1];
                            tx_idx_reg   <= tx_idx_reg + 3'd1;
                        end
                    end else
                        tx_cnt_reg <= tx_cnt_reg - 13'd1;
                end
                S_PARITY: begin
                    if (tx_cnt_reg == '0) begin
                        tx_cnt_reg   <= tx_div_reg;
                        tx_reg       <= 1'b1;
                        tx_state_reg <= S_STOP;
                    end else
                        tx_cnt_reg <= tx_cnt_reg - 13'd1;
                end
                S_STOP: begin
                    if (tx_cnt_reg == '0) begin
                        if (tx_stop2_reg) begin
                            tx_stop2_reg <= 1'b0;
                            tx_cnt_reg   <= tx_div_reg;
                        end else
                            tx_state_reg <= S_IDLE;
                    end else
                        tx_cnt_reg <= tx_cnt_reg - 13'd1;
                end
                default: tx_state_reg <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX engine ----------------
    logic rx_meta_reg, rx_s_reg;
    logic [12:0] rx_cnt_reg, rx_div_reg;
    logic [2:0]  rx_idx_reg;
    logic [DATA_W-1:0] rx_shift_reg;
    logic frame_err_set, parity_err_set, rx_ovf_set, tx_ovf_set;

    assign frame_err_set  = (rx_state_reg == S_STOP) && (rx_cnt_reg == '0) && !rx_s_reg;
    assign parity_err_set = (rx_state_reg == S_PARITY) && (rx_cnt_reg == '0)
                            && (rx_s_reg != ((^rx_shift_reg) ^ par_odd_reg));
    assign rx_ovf_set     = rx_push_reg && !flush && rx_full;
    assign tx_ovf_set     = tx_push_req && tx_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg  <= 1'b1;
            rx_s_reg     <= 1'b1;
            rx_state_reg <= S_IDLE;
            rx_cnt_reg   <= '0;
            rx_div_reg   <= '0;
            rx_idx_reg   <= '0;
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
            rx_push_reg  <= 1'b0;
        end else begin
            rx_meta_reg <= loopback_reg ? tx_reg : RX;
            rx_s_reg    <= rx_meta_reg;
            rx_push_reg <= 1'b0;
            case (rx_state_reg)
                S_IDLE: begin
                    if (!rx_s_reg) begin
                        rx_div_reg   <= div_eff;
                        rx_cnt_reg   <= half_m1;
                        rx_state_reg <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt_reg == '0) begin
                        rx_cnt_reg   <= rx_div_reg;
                        rx_idx_reg   <= '0;
                        rx_state_reg <= rx_s_reg ? S_IDLE : S_DATA;
                    end else
                        rx_cnt_reg <= rx_cnt_reg - 13'd1;
                end
                S_DATA: begin
                    if (rx_cnt_reg == '0) begin
                        rx_shift_reg <= {rx_s_reg, rx_shift_reg[DATA_W-1:1]};
                        rx_cnt_reg   <= rx_div_reg;
                        if (rx_idx_reg == 3'(DATA_W - 1))
                            rx_state_reg <= par_en_reg ? S_PARITY : S_STOP;
                        else
                            rx_idx_reg <= rx_idx_reg + 3'd1;
                    end else
                        rx_cnt_reg <= rx_cnt_reg - 13'd1;
                end
                S_PARITY: begin
                    if (rx_cnt_reg == '0) begin
                        rx_cnt_reg   <= rx_div_reg;
                        rx_state_reg <= S_STOP;
                    end else
                        rx_cnt_reg <= rx_cnt_reg - 13'd1;
                end
                S_STOP: begin
                    if (rx_cnt_reg == '0) begin
                        rx_data_reg  <= rx_shift_reg;
                        rx_push_reg  <= 1'b1;
                        rx_state_reg <= S_IDLE;
                    end else
                        rx_cnt_reg <= rx_cnt_reg - 13'd1;
                end
                default: rx_state_reg <= S_IDLE;
            endcase
        end
    end

    // ---------------- Registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            db_reg         <= 13'(DIV_RESET);
            loopback_reg   <= 1'b0;
            two_stop_reg   <= 1'b0;
            par_en_reg     <= 1'b0;
            par_odd_reg    <= 1'b0;
            rx_ovf_reg     <= 1'b0;
            tx_ovf_reg     <= 1'b0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
        end else begin
            if (wr && bus.ioaddr == 3'd2) db_reg[7:0]  <= databus;
            if (wr && bus.ioaddr == 3'd3) db_reg[12:8] <= databus[4:0];
            if (wr && bus.ioaddr == 3'd4) begin
                loopback_reg <= databus[0];
                two_stop_reg <= databus[1];
                par_en_reg   <= PAR_BUILD & databus[2];
                par_odd_reg  <= PAR_BUILD & databus[3];
            end
            // A new error on the clearing edge survives the clear.
            rx_ovf_reg     <= (rx_ovf_reg && !err_rd) || rx_ovf_set;
            tx_ovf_reg     <= (tx_ovf_reg && !err_rd) || tx_ovf_set;
            frame_err_reg  <= (frame_err_reg && !err_rd) || frame_err_set;
            parity_err_reg <= (parity_err_reg && !err_rd) || parity_err_set;
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (bus.ioaddr)
            3'd0:    if (!rx_empty) rdata = 8'(rx_mem[rx_rptr_reg[AW-1:0]]);
            3'd1:    rdata = {tx_free_sat, rx_used_sat};
            3'd2:    rdata = db_reg[7:0];
            3'd3:    rdata = {3'b000, db_reg[12:8]};
            3'd4:    rdata = {4'b0000, par_odd_reg, par_en_reg, two_stop_reg, loopback_reg};
            3'd5:    rdata = {4'b0000, parity_err_reg, frame_err_reg, tx_ovf_reg, rx_ovf_reg};
            default: rdata = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_spart_param.sv
// Scoreboard bench for spart_param (DIV_RESET = 3, 4 clk per bit): bus reads and TX frames are
// checked by monitors against expectations queued when the stimulus is issued.
module tb_spart_param;
    localparam int P = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spart_if bus_if ();
    wire  [7:0] databus;
    logic       drv_en   = 1'b0;
    logic [7:0] drv_data = 8'h00;
    logic       tx_line;
    logic       rx_line  = 1'b1;
    assign databus = drv_en ? drv_data : 8'hzz;

    spart_param #(.DATA_W(8), .FIFO_DEPTH(8), .DIV_RESET(3)) dut (
        .clk(clk), .rst(rst), .bus(bus_if), .databus(databus), .TX(tx_line), .RX(rx_line)
    );

    int checks = 0;
    int errors = 0;

    typedef struct { logic [7:0] val; string name; } rd_exp_t;
    typedef struct { logic [11:0] bits; int nbits; } frame_t;
    rd_exp_t rd_q[$];
    frame_t  tx_q[$];
    bit      mon_busy = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end else
            $display("ok   %s = %02h", name, act);
    endtask

    // Read monitor: every bus read cycle is matched against the oldest queued expectation.
    rd_exp_t rd_e;
    always @(negedge clk) begin
        if (!bus_if.iocs_n && bus_if.iorw_n) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got %02h expected none", databus);
            end else begin
                rd_e = rd_q.pop_front();
                chk(rd_e.name, databus, rd_e.val);
            end
        end
    end

    // TX monitor: each bit must hold its value for exactly P cycles.
    frame_t      mf;
    logic [11:0] mgot;
    int          mbad;
    bit          munexp;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tx_line === 1'b0) begin
                mon_busy = 1'b1;
                munexp   = (tx_q.size() == 0);
                if (munexp) begin
                    mf.bits  = 12'h200;
                    mf.nbits = 10;
                end else
                    mf = tx_q.pop_front();
                mgot = '0;
                mbad = 0;
                for (int b = 0; b < mf.nbits; b++) begin
                    for (int c = 0; c < P; c++) begin
                        if (b > 0 || c > 0) @(negedge clk);
                        if (c == 1) mgot[b] = tx_line;
                        if (tx_line !== mf.bits[b]) mbad++;
                    end
                end
                checks++;
                if (munexp || mbad != 0) begin
                    errors++;
                    $display("FAIL tx_frame: got %03h expected %03h (%0d bad cycles, unexpected=%0d)",
                             mgot, mf.bits, mbad, munexp);
                end else
                    $display("ok   tx_frame = %03h", mgot);
                mon_busy = 1'b0;
            end
        end
    end

    task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        bus_if.iocs_n = 1'b0; bus_if.iorw_n = 1'b0; bus_if.ioaddr = a;
        drv_data = d; drv_en = 1'b1;
        @(posedge clk); #1;
        bus_if.iocs_n = 1'b1; bus_if.iorw_n = 1'b1; drv_en = 1'b0;
        $display("wr   addr %0d data %02h", a, d);
    endtask

    task automatic bus_rd(input logic [2:0] a, input logic [7:0] exp, input string name);
        rd_exp_t e;
        e.val = exp;
        e.name = name;
        rd_q.push_back(e);
        @(posedge clk); #1;
        bus_if.iocs_n = 1'b0; bus_if.iorw_n = 1'b1; bus_if.ioaddr = a;
        @(posedge clk); #1;
        bus_if.iocs_n = 1'b1;
    endtask

    task automatic exp_frame(input logic [11:0] bits, input int nbits);
        frame_t f;
        f.bits = bits;
        f.nbits = nbits;
        tx_q.push_back(f);
    endtask

    task automatic wait_tx_idle(input int limit);
        int n = 0;
        while ((tx_q.size() != 0 || mon_busy) && n < limit) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL tx_wait: got %0d cycles expected < %0d", n, limit);
        end
        repeat (10) @(posedge clk);
    endtask

    task automatic wait_rx(input int limit);
        int n = 0;
        while (bus_if.rx_q_empty !== 1'b0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL rx_wait: got %0d cycles expected < %0d", n, limit);
        end
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        @(posedge clk); #1;
        rx_line = 1'b0;
        repeat (P) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx_line = d[i];
            repeat (P) @(posedge clk);
        end
        #1 rx_line = stop;
        repeat (P) @(posedge clk);
        #1 rx_line = 1'b1;
        repeat (2) @(posedge clk);
        $display("rx   frame %02h stop %0d", d, stop);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int lows;
    initial begin
        bus_if.iocs_n = 1'b1;
        bus_if.iorw_n = 1'b1;
        bus_if.ioaddr = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", {7'd0, tx_line}, 8'h01);
        chk("reset_tx_q_full", {7'd0, bus_if.tx_q_full}, 8'h00);
        chk("reset_rx_q_empty", {7'd0, bus_if.rx_q_empty}, 8'h01);
        rst = 1'b0;
        bus_rd(3'd1, 8'h80, "reset_status");
        bus_rd(3'd2, 8'h03, "reset_db_lo");
        bus_rd(3'd3, 8'h00, "reset_db_hi");
        bus_rd(3'd4, 8'h00, "reset_ctrl");
        bus_rd(3'd5, 8'h00, "reset_err");
        bus_rd(3'd6, 8'h00, "reserved_6");
        bus_rd(3'd0, 8'h00, "empty_pop");
        bus_rd(3'd1, 8'h80, "status_after_empty_pop");

        // Basic TX frame and start-bit latency.
        exp_frame(12'h34A, 10);
        bus_wr(3'd0, 8'hA5);
        chk("tx_before_start", {7'd0, tx_line}, 8'h01);
        @(posedge clk); #1;
        chk("tx_start_latency", {7'd0, tx_line}, 8'h00);
        wait_tx_idle(200);

        // Loopback: fill the FIFO behind a busy frame, overflow once, drain in order.
        bus_wr(3'd4, 8'h01);
        exp_frame(12'h3DC, 10);
        bus_wr(3'd0, 8'hEE);
        for (int i = 0; i < 8; i++) begin
            exp_frame(12'h200 | (12'(i) << 1), 10);
            bus_wr(3'd0, 8'(i));
        end
        chk("tx_q_full_after_8", {7'd0, bus_if.tx_q_full}, 8'h01);
        bus_wr(3'd0, 8'h08);
        bus_rd(3'd5, 8'h02, "err_tx_ovf");
        wait_rx(200);
        bus_rd(3'd0, 8'hEE, "loop_first");
        wait_tx_idle(1000);
        bus_rd(3'd1, 8'h88, "loop_status");
        for (int i = 0; i < 8; i++)
            bus_rd(3'd0, 8'(i), $sformatf("loop_rd%0d", i));
        chk("loop_rx_q_empty", {7'd0, bus_if.rx_q_empty}, 8'h01);
        bus_rd(3'd5, 8'h00, "loop_err_clear");

        // Parity (when built) with odd parity in loopback.
        bus_wr(3'd4, 8'h0D);
`ifdef SPART_PARITY_EN
        bus_rd(3'd4, 8'h0D, "ctrl_parity");
        exp_frame(12'h606, 11);
`else
        bus_rd(3'd4, 8'h01, "ctrl_no_parity");
        exp_frame(12'h206, 10);
`endif
        bus_wr(3'd0, 8'h03);
        wait_tx_idle(200);
        bus_rd(3'd0, 8'h03, "parity_rx");
        bus_rd(3'd5, 8'h00, "parity_err");

        // Two stop bits.
        bus_wr(3'd4, 8'h03);
        exp_frame(12'h702, 11);
        bus_wr(3'd0, 8'h81);
        wait_tx_idle(200);
        bus_rd(3'd0, 8'h81, "two_stop_rx");

        // External RX overflow.
        bus_wr(3'd4, 8'h00);
        for (int i = 0; i < 12; i++)
            send_rx(8'h30 + 8'(i), 1'b1);
        repeat (4) @(posedge clk);
        bus_rd(3'd1, 8'h88, "rx_full_status");
        bus_rd(3'd5, 8'h01, "err_rx_ovf");
        bus_rd(3'd5, 8'h00, "err_rx_ovf_cleared");
        bus_rd(3'd0, 8'h30, "rx_first");
        bus_wr(3'd4, 8'h80);
        chk("flush_rx_q_empty", {7'd0, bus_if.rx_q_empty}, 8'h01);

        // Framing error and glitch rejection.
        send_rx(8'h5A, 1'b0);
        repeat (4) @(posedge clk);
        chk("frame_err_pushed", {7'd0, bus_if.rx_q_empty}, 8'h00);
        bus_rd(3'd0, 8'h5A, "frame_err_data");
        bus_rd(3'd5, 8'h04, "err_frame");
        @(posedge clk); #1 rx_line = 1'b0;
        @(posedge clk); #1 rx_line = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("glitch_rx_q_empty", {7'd0, bus_if.rx_q_empty}, 8'h01);
        bus_rd(3'd5, 8'h00, "glitch_err");

        // DB change mid-frame, then flush: frame finishes at the old rate.
        exp_frame(12'h278, 10);
        bus_wr(3'd0, 8'h3C);
        bus_wr(3'd0, 8'h11);
        bus_wr(3'd3, 8'h07);
        bus_rd(3'd3, 8'h07, "db_hi_new");
        bus_wr(3'd4, 8'h80);
        chk("flush_tx_q_full", {7'd0, bus_if.tx_q_full}, 8'h00);
        bus_rd(3'd1, 8'h80, "flush_status");
        wait_tx_idle(200);
        lows = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx_line !== 1'b1) lows++;
        end
        chk("tx_quiet_after_flush", 8'(lows), 8'h00);
        bus_rd(3'd4, 8'h00, "ctrl_after_flush");
        bus_rd(3'd2, 8'h03, "db_lo_kept");
        chk("pending_reads", 8'(rd_q.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
